// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - multi-port circular return-address stack with checkpoint/restore
module ras_stack #(
  parameter int DATA  = 64,
  parameter int DEPTH = 8,
  parameter int PUSH  = 1,
  parameter int POP   = 1,
  parameter int CKPT  = 4,
  localparam int IW   = (CKPT > 1) ? $clog2(CKPT) : 1,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_,
  input  logic [PUSH-1:0]      push_,
  input  logic [PUSH*DATA-1:0] wd,
  input  logic [POP-1:0]       pop_,
  output logic [POP*DATA-1:0]  rd,
  output logic [POP-1:0]       v,
  input  logic                 ckpt_,
  input  logic [IW-1:0]        ckpt_id,
  input  logic                 restore_,
  input  logic [IW-1:0]        restore_id,
  output logic [PW:0]          count,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf
);

  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [DATA-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW:0]     cnt;
  logic [PW-1:0]   ck_ptr [CKPT];
  logic [PW:0]     ck_cnt [CKPT];
  logic            ovf_q;

  logic [PW:0]     wnum, rnum, rn, c, nxt_cnt, rs_cnt;
  logic [PW-1:0]   base, nxt_ptr, rs_ptr;
  logic            wstop, rstop;

  // Lane counts: only the leading run of asserted (low) enables counts
  always_comb begin
    wnum  = '0;
    wstop = 1'b0;
    for (int i = 0; i < PUSH; i++) begin
      if (push_[i]) wstop = 1'b1;
      else if (!wstop) wnum = wnum + 1'b1;
    end
    rnum  = '0;
    rstop = 1'b0;
    for (int j = 0; j < POP; j++) begin
      if (pop_[j]) rstop = 1'b1;
      else if (!rstop) rnum = rnum + 1'b1;
    end
  end

  // Next pointer/count: pops clamp at empty, then pushes land in the freed slots;
  // a restore replaces the whole update with the saved pair
  always_comb begin
    rn     = (rnum > cnt) ? cnt : rnum;
    base   = ptr - rn[PW-1:0];
    c      = cnt - rn + wnum;
    rs_ptr = '0;
    rs_cnt = '0;
    if (int'(restore_id) < CKPT) begin
      rs_ptr = ck_ptr[restore_id];
      rs_cnt = ck_cnt[restore_id];
    end
    if (!restore_) begin
      nxt_ptr = rs_ptr;
      nxt_cnt = rs_cnt;
    end else begin
      nxt_ptr = base + wnum[PW-1:0];
      nxt_cnt = (c > DEPTH_C) ? DEPTH_C : c;
    end
  end

  // Read lanes: lane j shows the j-th entry below the top
  always_comb begin
    rd = '0;
    v  = '0;
    for (int j = 0; j < POP; j++) begin
      rd[j*DATA +: DATA] = mem[ptr - PW'(j + 1)];
      v[j]               = (cnt > (PW+1)'(j));
    end
  end

  assign count = cnt;
  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign ovf   = ovf_q;

  // Entry storage: flush leaves contents alone, restore never rewinds data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (flush_ && restore_) begin
      for (int i = 0; i < PUSH; i++) begin
        if ((PW+1)'(i) < wnum) mem[base + PW'(i)] <= wd[i*DATA +: DATA];
      end
    end
  end

  // Pointer, count, overflow pulse and checkpoint slots
  always_ff @(posedge clk) begin
    if (reset || !flush_) begin
      ptr   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < CKPT; k++) begin
        ck_ptr[k] <= '0;
        ck_cnt[k] <= '0;
      end
    end else begin
      ptr   <= nxt_ptr;
      cnt   <= nxt_cnt;
      ovf_q <= restore_ && (c > DEPTH_C);
      if (!ckpt_ && int'(ckpt_id) < CKPT) begin
        ck_ptr[ckpt_id] <= nxt_ptr;
        ck_cnt[ckpt_id] <= nxt_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ras_stack.sv
// tb/tb_ras_stack.sv - self-checking bench for ras_stack against a behavioural stack model
module tb_ras_stack;
  localparam int DATA = 8, DEPTH = 8, PUSH = 2, POP = 2, CKPT = 4;

  logic        clk = 1'b0;
  logic        reset, flush_, ckpt_, restore_;
  logic [1:0]  push_, pop_, ckpt_id, restore_id;
  logic [15:0] wd;
  logic [15:0] rd;
  logic [1:0]  v;
  logic [3:0]  count;
  logic        full, empty, ovf;

  int checks = 0;
  int errors = 0;

  int m_data [DEPTH];
  int m_ptr, m_cnt, m_ovf;
  int s_ptr [CKPT];
  int s_cnt [CKPT];

  ras_stack #(.DATA(DATA), .DEPTH(DEPTH), .PUSH(PUSH), .POP(POP), .CKPT(CKPT)) dut (
    .clk(clk), .reset(reset), .flush_(flush_), .push_(push_), .wd(wd), .pop_(pop_),
    .rd(rd), .v(v), .ckpt_(ckpt_), .ckpt_id(ckpt_id), .restore_(restore_),
    .restore_id(restore_id), .count(count), .full(full), .empty(empty), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic int m_top(int j);
    return m_data[(m_ptr - 1 - j + 2*DEPTH) % DEPTH];
  endfunction

  task automatic model_update();
    int wn, rn, base, c;
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) m_data[k] = 0;
      for (int k = 0; k < CKPT; k++) begin s_ptr[k] = 0; s_cnt[k] = 0; end
      m_ptr = 0; m_cnt = 0; m_ovf = 0;
    end else if (!flush_) begin
      for (int k = 0; k < CKPT; k++) begin s_ptr[k] = 0; s_cnt[k] = 0; end
      m_ptr = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      if (!restore_) begin
        m_ptr = s_ptr[restore_id];
        m_cnt = s_cnt[restore_id];
        m_ovf = 0;
      end else begin
        wn = 0;
        while (wn < PUSH && !push_[wn]) wn++;
        rn = 0;
        while (rn < POP && !pop_[rn]) rn++;
        if (rn > m_cnt) rn = m_cnt;
        base = (m_ptr - rn + DEPTH) % DEPTH;
        for (int i = 0; i < wn; i++) m_data[(base + i) % DEPTH] = int'(wd[i*DATA +: DATA]);
        m_ptr = (base + wn) % DEPTH;
        c = m_cnt - rn + wn;
        m_cnt = (c > DEPTH) ? DEPTH : c;
        m_ovf = (c > DEPTH) ? 1 : 0;
      end
      if (!ckpt_) begin
        s_ptr[ckpt_id] = m_ptr;
        s_cnt[ckpt_id] = m_cnt;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; flush_ = 1'b1; push_ = 2'b11; pop_ = 2'b11;
    ckpt_ = 1'b1; restore_ = 1'b1; ckpt_id = 2'd0; restore_id = 2'd0; wd = 16'h0;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (count !== 4'd0) begin errors++; $display("FAIL reset count: got %0d expected 0", count); end checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset empty: got %0b expected 1", empty); end checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset full: got %0b expected 0", full); end checks++;
    if (v !== 2'b00) begin errors++; $display("FAIL reset v: got %b expected 00", v); end checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf: got %0b expected 0", ovf); end checks++;
  endtask

  task automatic test_push_basic();
    do_reset();
    push_ = 2'b00; wd = {8'h22, 8'h11}; tick(); idle();
    if (count !== 4'd2) begin errors++; $display("FAIL push count: got %0d expected 2", count); end checks++;
    if (rd[7:0] !== 8'h22) begin errors++; $display("FAIL push rd0: got %h expected 22", rd[7:0]); end checks++;
    if (rd[15:8] !== 8'h11) begin errors++; $display("FAIL push rd1: got %h expected 11", rd[15:8]); end checks++;
    if (v !== 2'b11) begin errors++; $display("FAIL push v: got %b expected 11", v); end checks++;
    if (empty !== 1'b0) begin errors++; $display("FAIL push empty: got %0b expected 0", empty); end checks++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_ = 2'b00; wd = {8'(2*k + 2), 8'(2*k + 1)}; tick(); idle();
      if (ovf !== (k == 4)) begin errors++; $display("FAIL ovf push%0d: got %0b expected %0b", k, ovf, k == 4); end checks++;
    end
    if (count !== 4'd8) begin errors++; $display("FAIL ovf count: got %0d expected 8", count); end checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL ovf full: got %0b expected 1", full); end checks++;
    tick();
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf idle: got %0b expected 0", ovf); end checks++;
    for (int k = 0; k < 4; k++) begin
      if (rd[7:0] !== 8'(10 - 2*k)) begin errors++; $display("FAIL drain rd0 %0d: got %h expected %h", k, rd[7:0], 10 - 2*k); end checks++;
      if (rd[15:8] !== 8'(9 - 2*k)) begin errors++; $display("FAIL drain rd1 %0d: got %h expected %h", k, rd[15:8], 9 - 2*k); end checks++;
      pop_ = 2'b00; tick(); idle();
    end
    if (count !== 4'd0) begin errors++; $display("FAIL drain count: got %0d expected 0", count); end checks++;
  endtask

  task automatic test_pop_push();
    do_reset();
    push_ = 2'b10; wd = {8'h00, 8'h55}; tick(); idle();
    pop_ = 2'b00; push_ = 2'b10; wd = {8'hFF, 8'h66}; tick(); idle();
    if (count !== 4'd1) begin errors++; $display("FAIL poppush count: got %0d expected 1", count); end checks++;
    if (rd[7:0] !== 8'h66) begin errors++; $display("FAIL poppush rd0: got %h expected 66", rd[7:0]); end checks++;
    if (v !== 2'b01) begin errors++; $display("FAIL poppush v: got %b expected 01", v); end checks++;
    pop_ = 2'b00; tick(); tick(); idle();
    if (count !== 4'd0) begin errors++; $display("FAIL underflow count: got %0d expected 0", count); end checks++;
    if (v !== 2'b00) begin errors++; $display("FAIL underflow v: got %b expected 00", v); end checks++;
  endtask

  task automatic test_noncontig();
    do_reset();
    push_ = 2'b10; wd = {8'h00, 8'h77}; tick(); idle();
    push_ = 2'b01; wd = {8'h88, 8'h99}; tick(); idle();
    if (count !== 4'd1) begin errors++; $display("FAIL noncontig count: got %0d expected 1", count); end checks++;
    if (rd[7:0] !== 8'h77) begin errors++; $display("FAIL noncontig rd0: got %h expected 77", rd[7:0]); end checks++;
  endtask

  task automatic test_ckpt_restore();
    do_reset();
    push_ = 2'b00; wd = {8'hB0, 8'hA0}; ckpt_ = 1'b0; ckpt_id = 2'd2; tick(); idle();
    push_ = 2'b10; wd = {8'h00, 8'hC0}; tick(); idle();
    pop_ = 2'b00; tick(); pop_ = 2'b10; tick(); idle();
    restore_ = 1'b0; restore_id = 2'd2; push_ = 2'b00; wd = 16'hEEEE;
    ckpt_ = 1'b0; ckpt_id = 2'd3; tick(); idle();
    if (count !== 4'd2) begin errors++; $display("FAIL restore count: got %0d expected 2", count); end checks++;
    if (rd[7:0] !== 8'hB0) begin errors++; $display("FAIL restore rd0: got %h expected B0", rd[7:0]); end checks++;
    if (rd[15:8] !== 8'hA0) begin errors++; $display("FAIL restore rd1: got %h expected A0", rd[15:8]); end checks++;
    pop_ = 2'b00; tick(); idle();
    restore_ = 1'b0; restore_id = 2'd3; tick(); idle();
    if (count !== 4'd2) begin errors++; $display("FAIL ckpt-on-restore count: got %0d expected 2", count); end checks++;
    if (rd[7:0] !== 8'hB0) begin errors++; $display("FAIL ckpt-on-restore rd0: got %h expected B0", rd[7:0]); end checks++;
  endtask

  task automatic test_flush();
    do_reset();
    push_ = 2'b00; wd = {8'h12, 8'h34}; ckpt_ = 1'b0; ckpt_id = 2'd1; tick(); idle();
    flush_ = 1'b0; push_ = 2'b00; restore_ = 1'b0; restore_id = 2'd1; ckpt_ = 1'b0; ckpt_id = 2'd0;
    tick(); idle();
    if (count !== 4'd0) begin errors++; $display("FAIL flush count: got %0d expected 0", count); end checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL flush empty: got %0b expected 1", empty); end checks++;
    for (int s = 0; s < CKPT; s++) begin
      restore_ = 1'b0; restore_id = 2'(s); tick(); idle();
      if (count !== 4'd0) begin errors++; $display("FAIL flush slot%0d count: got %0d expected 0", s, count); end checks++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 4; k++) begin push_ = 2'b00; wd = {8'(k), 8'(k + 16)}; tick(); end
    reset = 1'b1; push_ = 2'b00; tick(); idle();
    if (count !== 4'd0) begin errors++; $display("FAIL midreset count: got %0d expected 0", count); end checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL midreset flags: got empty=%0b full=%0b expected 1 0", empty, full); end checks++;
    if (v !== 2'b00) begin errors++; $display("FAIL midreset v: got %b expected 00", v); end checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL midreset ovf: got %0b expected 0", ovf); end checks++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      push_      = 2'($urandom);
      pop_       = 2'($urandom);
      wd         = 16'($urandom);
      ckpt_      = ($urandom_range(0, 3) != 0);
      ckpt_id    = 2'($urandom);
      restore_   = ($urandom_range(0, 7) != 0);
      restore_id = 2'($urandom);
      flush_     = ($urandom_range(0, 39) != 0);
      reset      = ($urandom_range(0, 99) == 0);
      tick();
      if (count !== 4'(m_cnt)) begin errors++; $display("FAIL rand%0d count: got %0d expected %0d", n, count, m_cnt); end checks++;
      if (ovf !== 1'(m_ovf)) begin errors++; $display("FAIL rand%0d ovf: got %0b expected %0d", n, ovf, m_ovf); end checks++;
      if (full !== (m_cnt == DEPTH) || empty !== (m_cnt == 0)) begin errors++; $display("FAIL rand%0d flags: got full=%0b empty=%0b cnt=%0d", n, full, empty, m_cnt); end checks++;
      if (v !== {m_cnt > 1, m_cnt > 0}) begin errors++; $display("FAIL rand%0d v: got %b cnt %0d", n, v, m_cnt); end checks++;
      if (m_cnt > 0) begin
        if (rd[7:0] !== 8'(m_top(0))) begin errors++; $display("FAIL rand%0d rd0: got %h expected %h", n, rd[7:0], m_top(0)); end checks++;
      end
      if (m_cnt > 1) begin
        if (rd[15:8] !== 8'(m_top(1))) begin errors++; $display("FAIL rand%0d rd1: got %h expected %h", n, rd[15:8], m_top(1)); end checks++;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_push_basic();
    test_overflow();
    test_pop_push();
    test_noncontig();
    test_ckpt_restore();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
Parametrised multi-port circular stack: up to PUSH pushes and POP pops per cycle, with speculative checkpoint/restore of stack state.
- Overflow wraps and overwrites the oldest entry instead of stalling.
- Underflow clamps at empty.
- Used as a return-address stack in the fetch/branch-predict path, where mispredicts restore a saved pointer/count.

Parameters:
DATA, 64, entry width in bits
DEPTH, 8, entry count; power of two, >= 4
PUSH, 1, push lanes per cycle; 1 <= PUSH <= DEPTH/2
POP, 1, pop/read lanes per cycle; 1 <= POP <= DEPTH/2
CKPT, 4, checkpoint slots; >= 1

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
flush_  in  1  clear stack and all checkpoints, active-low
push_  in  PUSH  per-lane push enable, active-low
wd  in  PUSH x DATA  push data; lane 0 pushed first (ends deepest)
pop_  in  POP  per-lane pop enable, active-low
rd  out  POP x DATA  rd[j] = j-th entry from top
v  out  POP  rd[j] valid
ckpt_  in  1  save checkpoint, active-low
ckpt_id  in  clog2(CKPT) (min 1)  slot to save into
restore_  in  1  restore checkpoint, active-low
restore_id  in  clog2(CKPT) (min 1)  slot to restore from
count  out  clog2(DEPTH)+1  live entry count
full  out  1  count == DEPTH
empty  out  1  count == 0
ovf  out  1  registered pulse: previous cycle overwrote >= 1 oldest entry

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high.
- Reset values: ptr=0, count=0, all data=0, all checkpoint slots {ptr=0,count=0}, ovf=0. Outputs then read v=0, empty=1, full=0, count=0.
- Read path, combinational from registers, zero latency:
  - rd[j] = data[(ptr-1-j) mod DEPTH].
  - v[j] = (j < count).
  - rd is don't-care when v=0.
- Lane counts:
  - wnum = number of consecutive asserted push_ lanes starting at lane 0. Lanes after the first deasserted lane are ignored.
  - rnum is derived from pop_ the same way.
- Priority per cycle: reset > flush_ > restore_ > normal push/pop.
- flush_ low:
  - ptr=0, count=0, all checkpoints zeroed, ovf=0.
  - Push, pop, ckpt and restore are ignored. Data array is untouched.
- restore_ low:
  - {ptr,count} <= slot[restore_id].
  - Push and pop that cycle are ignored; ovf=0.
  - Data is not restored: entries overwritten since the save return new contents.
- Normal update, pops applied before pushes:
  - rn = min(rnum, count). Excess pops are dropped silently.
  - base = (ptr - rn) mod DEPTH.
  - Push lane i < wnum writes data[(base+i) mod DEPTH] <= wd[i].
  - ptr' = (base + wnum) mod DEPTH.
  - c = count - rn + wnum; count' = min(c, DEPTH).
  - Next-cycle ovf = (c > DEPTH).
- Pop and push in the same cycle: popped entries are the ones visible on rd this cycle. Pushes land in the freed slots.
- Checkpoint save:
  - When ckpt_ is low, slot[ckpt_id] <= {ptr',count'}, the post-update state of the same cycle, including a restore applied that cycle.
  - ckpt_ is ignored under flush_.
  - ckpt_id == restore_id in the same cycle: the slot ends holding the restored value.
- Wrap-around: ptr is modulo DEPTH throughout. count saturates at DEPTH and the oldest entries are lost silently apart from ovf.
- Mid-operation reset: takes effect at the next edge regardless of any other input; no partial update.

Test Plan (DATA=8, DEPTH=8, PUSH=2, POP=2, CKPT=4):
- Reset, then push lanes 0,1 = 0x11,0x22 -> next cycle count=2, rd[0]=0x22, rd[1]=0x11, v=2'b11, empty=0.
- Push 0x01..0x0A two per cycle over 5 cycles -> count=8, full=1, rd[0]=0x0A, rd[1]=0x09. ovf=1 exactly on the cycle after the 5th push, 0 otherwise. Popping 8 entries returns 0x0A down to 0x03.
- From count=1 (top 0x55): pop both lanes plus push lane 0 = 0x66 -> rn=1, count=1, rd[0]=0x66, v=2'b01. Pop both lanes on empty -> count stays 0, v=0.
- Non-contiguous push_ = 2'b01 (lane 0 deasserted, lane 1 asserted) -> wnum=0, count unchanged.
- Push 0xA0,0xB0 with ckpt_ slot 2 in the same cycle, then push 0xC0, pop 3, assert restore_ slot 2 -> count=2, rd[0]=0xB0, rd[1]=0xA0. A push issued in the restore cycle is ignored.
- Issue flush_ together with push, restore_ and ckpt_ -> count=0, empty=1. A later restore of any slot yields count=0. Assert reset in the middle of a push burst -> all outputs at their reset values on the next cycle.
